// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// opcode classes and the datapath mux select codes.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWR,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] OP_DPR = 3'b000;
    localparam logic [2:0] OP_DPI = 3'b001;
    localparam logic [2:0] OP_MEM = 3'b010;
    localparam logic [2:0] OP_BR  = 3'b011;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;

endpackage

// File: rtl/mcu_lane_counter.sv
// Vector lane index: counts 0..LANES-1, saturating at the last lane until cleared.
module mcu_lane_counter #(
    parameter  int LANES  = 4,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [LANE_W-1:0] idx_o,
    output logic              last_o
);

    logic [LANE_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (inc_i && !last_o) begin
            idx_d = idx_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign last_o = (idx_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing fetch/decode/execute/writeback, with a lane loop for
// vector instructions, memory-stall freeze and illegal-opcode reporting.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter  int LANES     = 4,
    parameter  int ALUCTRL_W = 3,
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           Opcode,
    input  logic                 V,
    input  logic [2:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 Stall,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 RegW,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic [LANE_W-1:0]    LaneIdx,
    output logic                 Fault
);

    state_t state_q, state_d;
    logic   laneInc, laneClr, laneLast;
    logic   pcsHit;

    mcu_lane_counter #(.LANES(LANES)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (laneInc),
        .clr_i  (laneClr),
        .idx_o  (LaneIdx),
        .last_o (laneLast)
    );

    assign pcsHit = (Rd == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        laneInc = 1'b0;
        laneClr = 1'b0;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DPR:  state_d = S_EXECR;
                    OP_DPI:  state_d = S_EXECI;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            // Writeback states close one lane; vectors loop back for the next lane.
            S_MEMWB, S_MEMWR, S_ALUWB: begin
                if (V && !laneLast) begin
                    laneInc = 1'b1;
                    if (Opcode == OP_MEM) begin
                        state_d = S_MEMADR;
                    end else if (Opcode == OP_DPR) begin
                        state_d = S_EXECR;
                    end else begin
                        state_d = S_EXECI;
                    end
                end else begin
                    laneClr = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        if (Stall) begin
            state_d = state_q;
            laneInc = 1'b0;
            laneClr = 1'b0;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemW       = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_DP;
        ALUControl = ALUCTRL_W'(ALU_ADD);
        FlagW      = 2'b00;
        Fault      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                Fault     = Opcode[2];
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_MEM;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegW      = 1'b1;
                PCWrite   = pcsHit && !V;
                Fault     = pcsHit && V;
            end
            S_EXECR: ALUControl = ALUCTRL_W'(Funct[2:1]);
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALUCTRL_W'(Funct[2:1]);
            end
            // Flags are architectural state, so only lane 0 may update them.
            S_ALUWB: begin
                RegW    = 1'b1;
                PCWrite = pcsHit && !V;
                Fault   = pcsHit && V;
                if (Funct[0] && (LaneIdx == '0)) begin
                    FlagW = Funct[2] ? 2'b10 : 2'b11;
                end
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_BR;
                ResultSrc = RES_ALURES;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        if (Stall || !rst_n) begin
            PCWrite = 1'b0;
            IRWrite = 1'b0;
            MemW    = 1'b0;
            RegW    = 1'b0;
            FlagW   = 2'b00;
            Fault   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks scalar, vector, PCS,
// illegal-opcode, stall and mid-instruction reset sequences with hand-written expectations.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst_n;
    logic [2:0] Opcode;
    logic       V;
    logic [2:0] Funct;
    logic [3:0] Rd;
    logic       Stall;
    logic       PCWrite, AdrSrc, MemW, IRWrite, RegW, Fault;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, FlagW, LaneIdx;
    logic [2:0] ALUControl;

    int checks   = 0;
    int failures = 0;

    multicycle_control_unit #(.LANES(4), .ALUCTRL_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .V          (V),
        .Funct      (Funct),
        .Rd         (Rd),
        .Stall      (Stall),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemW       (MemW),
        .IRWrite    (IRWrite),
        .RegW       (RegW),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .LaneIdx    (LaneIdx),
        .Fault      (Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs one expected output vector in port order.
    function automatic logic [20:0] mk(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic regw,
                                       input logic [1:0] res, input logic [1:0] srca,
                                       input logic [1:0] srcb, input logic [1:0] imm,
                                       input logic [2:0] aluc, input logic [1:0] flagw,
                                       input logic [1:0] lane, input logic fault);
        return {pcw, adr, memw, irw, regw, res, srca, srcb, imm, aluc, flagw, lane, fault};
    endfunction

    task automatic checkOutput(input string tag, input logic [20:0] expected);
        logic [20:0] observed;
        observed = {PCWrite, AdrSrc, MemW, IRWrite, RegW, ResultSrc, ALUSrcA, ALUSrcB,
                    ImmSrc, ALUControl, FlagW, LaneIdx, Fault};
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic v,
                                 input logic [2:0] fn, input logic [3:0] rd);
        Opcode = op;
        V      = v;
        Funct  = fn;
        Rd     = rd;
    endtask

    logic [20:0] eReset, eFetch, eDecode;

    initial begin
        eReset  = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'd0, 2'b00, 2'd0, 0);
        eFetch  = mk(1, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'd0, 2'b00, 2'd0, 0);
        eDecode = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'd0, 2'b00, 2'd0, 0);

        rst_n = 1'b0;
        Stall = 1'b0;
        applyStimulus(3'b000, 1'b0, 3'b000, 4'd0);
        #12;
        checkOutput("reset_hold", eReset);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 checkOutput("first_fetch", eFetch);

        // Scalar LDR r2
        applyStimulus(3'b010, 1'b0, 3'b001, 4'd2);
        step(); checkOutput("ldr_decode", eDecode);
        step(); checkOutput("ldr_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 3'd0, 2'b00, 2'd0, 0));
        step(); checkOutput("ldr_memrd",  mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 2'd0, 0));
        step(); checkOutput("ldr_memwb",  mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 2'd0, 0));
        step(); checkOutput("ldr_fetch",  eFetch);

        // Vector ADD immediate with S=1 over 4 lanes
        applyStimulus(3'b001, 1'b1, 3'b001, 4'd3);
        step(); checkOutput("vadd_decode", eDecode);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("vadd_execi_l%0d", i),
                        mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'd0, 2'b00, 2'(i), 0));
            step();
            checkOutput($sformatf("vadd_aluwb_l%0d", i),
                        mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0,
                           (i == 0) ? 2'b11 : 2'b00, 2'(i), 0));
        end
        step(); checkOutput("vadd_fetch", eFetch);

        // Scalar ORR register, S=1, Rd=15: PC written alongside the register
        applyStimulus(3'b000, 1'b0, 3'b101, 4'd15);
        step(); checkOutput("pcs_decode", eDecode);
        step(); checkOutput("pcs_execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd2, 2'b00, 2'd0, 0));
        step(); checkOutput("pcs_aluwb", mk(1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 2'b10, 2'd0, 0));
        step(); checkOutput("pcs_fetch", eFetch);

        // Illegal opcode
        applyStimulus(3'b101, 1'b0, 3'b000, 4'd0);
        step(); checkOutput("ill_decode", mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 3'd0, 2'b00, 2'd0, 1));
        step(); checkOutput("ill_fetch", eFetch);

        // Branch with V=1 still takes 3 cycles
        applyStimulus(3'b011, 1'b1, 3'b000, 4'd0);
        step(); checkOutput("br_decode", eDecode);
        step(); checkOutput("br_branch", mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b10, 3'd0, 2'b00, 2'd0, 0));
        step(); checkOutput("br_fetch", eFetch);

        // Scalar STR stalled for 3 cycles in MEMWR
        applyStimulus(3'b010, 1'b0, 3'b000, 4'd1);
        step(); checkOutput("str_decode", eDecode);
        step(); checkOutput("str_memadr", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 3'd0, 2'b00, 2'd0, 0));
        step();
        Stall = 1'b1;
        #1 checkOutput("str_stall0", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 2'd0, 0));
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput($sformatf("str_stall%0d", i),
                        mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 2'd0, 0));
        end
        Stall = 1'b0;
        #1 checkOutput("str_release", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 2'd0, 0));
        step(); checkOutput("str_fetch", eFetch);

        // Vector STR interrupted by reset during lane 2
        applyStimulus(3'b010, 1'b1, 3'b000, 4'd4);
        step(); checkOutput("vstr_decode", eDecode);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("vstr_memadr_l%0d", i),
                        mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 3'd0, 2'b00, 2'(i), 0));
            step();
            checkOutput($sformatf("vstr_memwr_l%0d", i),
                        mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 2'b00, 2'(i), 0));
        end
        #1 rst_n = 1'b0;
        #1 checkOutput("vstr_reset_async", eReset);
        step(); checkOutput("vstr_reset_hold", eReset);
        #1 rst_n = 1'b1;
        #1 checkOutput("vstr_after_reset", eFetch);
        step(); checkOutput("vstr_restart_decode", eDecode);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
